// File: rtl/multibyte_add_seq.sv
// Byte-serial wide adder sequencer: drives an external 8-bit combinational adder LSB first.
// Optional feature macro: SUB_EN adds the 'sub' port (latches ~op_b and forces carry-in to 1).
// Latency: accept at E0 -> out_valid after E0+NBYTES; one operation per NBYTES+2 cycles.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
`ifdef SUB_EN
  input  logic                  sub,
`endif
  output logic [7:0]            add_in1,
  output logic [7:0]            add_in2,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [8*NBYTES-1:0]   a_reg, b_reg;
  logic                  carry_reg;
  logic [IW-1:0]         idx;
  logic                  accept;
  logic                  do_sub;

`ifdef SUB_EN
  assign do_sub = sub;
`else
  assign do_sub = 1'b0;
`endif

  assign accept = in_valid && (state == IDLE);
  assign cout   = carry_reg;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/adder-drive outputs; adder inputs are zero outside RUN
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_in1   = 8'h00;
    add_in2   = 8'h00;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        add_in1 = a_reg[{idx, 3'b000} +: 8];
        add_in2 = b_reg[{idx, 3'b000} +: 8];
        add_cin = carry_reg;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at acceptance, then one byte of sum and the ripple carry per RUN cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
    end else if (accept) begin
      a_reg     <= op_a;
      b_reg     <= do_sub ? ~op_b : op_b;
      carry_reg <= do_sub ? 1'b1 : cin;
      idx       <= '0;
      result    <= '0;
    end else if (state == RUN) begin
      result[{idx, 3'b000} +: 8] <= add_sum;
      carry_reg                  <= add_cout;
      idx                        <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

endmodule
